// File: rtl/pyjamask96_pkg.sv
// Shared types and constants for the pyjamask96 loader: FSM states,
// block/key sizes and default handshake timing.
package pyjamask96_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_START,
    ST_WAIT_V,
    ST_DRAIN
  } state_t;

  localparam int PJ96_BLOCK_BYTES  = 12;
  localparam int PJ96_KEY_BYTES    = 16;
  localparam int PJ96_GAP_CYCLES   = 1;
  localparam int PJ96_START_CYCLES = 2;

endpackage

// File: rtl/pyjamask96_loader.sv
// Serialises one 96-bit block and one 128-bit key into the pyjamask96 core's
// byte-wide load protocol, strobes start and waits for the result window.
module pyjamask96_loader
  import pyjamask96_pkg::*;
#(
  parameter int GAP_CYCLES   = PJ96_GAP_CYCLES,
  parameter int START_CYCLES = PJ96_START_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [8*PJ96_BLOCK_BYTES-1:0] block_in,
  input  logic [8*PJ96_KEY_BYTES-1:0]   key_in,
  output logic                          load,
  output logic                          start,
  output logic [7:0]                    byte_in,
  output logic [7:0]                    byte_key_in,
  input  logic                          core_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int BLOCK_W = 8 * PJ96_BLOCK_BYTES;
  localparam int KEY_W   = 8 * PJ96_KEY_BYTES;
  localparam int CNT_W   = 8;
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);

  state_t             state, nxt_state;
  logic [BLOCK_W-1:0] blk_q, nxt_blk;
  logic [KEY_W-1:0]   key_q, nxt_key;
  logic [3:0]         idx, nxt_idx;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic               nxt_done;

  logic [KEY_W-1:0]   blk_pad;
  logic               load_d, start_d, busy_d, done_d, in_ready_d;
  logic [7:0]         byte_in_d, byte_key_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
      blk_q <= '0;
      key_q <= '0;
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
      cnt   <= nxt_cnt;
      blk_q <= nxt_blk;
      key_q <= nxt_key;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cnt   = cnt;
    nxt_blk   = blk_q;
    nxt_key   = key_q;
    nxt_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          nxt_state = ST_LOAD;
          nxt_idx   = '0;
          nxt_blk   = block_in;
          nxt_key   = key_in;
        end
      end
      ST_LOAD: begin
        if (idx == 4'd15) begin
          nxt_state = ST_GAP;
          nxt_cnt   = '0;
        end else begin
          nxt_idx = idx + 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          nxt_state = ST_START;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      ST_START: begin
        if (cnt == START_LAST) begin
          nxt_state = ST_WAIT_V;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      ST_WAIT_V: begin
        if (core_valid) begin
          nxt_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!core_valid) begin
          nxt_state = ST_IDLE;
          nxt_done  = 1'b1;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they describe; the block is zero-padded so bytes 12..15 read 0.
  always_comb begin
    blk_pad    = {{(KEY_W - BLOCK_W){1'b0}}, nxt_blk};
    load_d     = (nxt_state == ST_LOAD);
    start_d    = (nxt_state == ST_START);
    byte_in_d  = load_d ? blk_pad[{nxt_idx, 3'b000} +: 8] : 8'h00;
    byte_key_d = load_d ? nxt_key[{nxt_idx, 3'b000} +: 8] : 8'h00;
    busy_d     = (nxt_state != ST_IDLE);
    done_d     = nxt_done;
    // Holding in_ready low in the done cycle gives upstream one quiet cycle.
    in_ready_d = (nxt_state == ST_IDLE) && (state == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready    <= 1'b0;
      load        <= 1'b0;
      start       <= 1'b0;
      byte_in     <= 8'h00;
      byte_key_in <= 8'h00;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      in_ready    <= in_ready_d;
      load        <= load_d;
      start       <= start_d;
      byte_in     <= byte_in_d;
      byte_key_in <= byte_key_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_pyjamask96_loader.sv
// Directed self-checking bench for pyjamask96_loader: default timing on dut_a,
// GAP_CYCLES=3 / START_CYCLES=1 on dut_b driven from the same inputs.
module tb_pyjamask96_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [95:0]  block_in = '0;
  logic [127:0] key_in = '0;
  logic         core_valid = 1'b0;

  logic       in_ready, load, start, busy, done;
  logic [7:0] byte_in, byte_key_in;
  logic       in_ready_b, load_b, start_b, busy_b, done_b;
  logic [7:0] byte_in_b, byte_key_in_b;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [95:0]  BLK_A = 96'h50796a616d61736b39363a29;
  localparam logic [127:0] KEY_B = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [95:0]  BLK_B = 96'h0102030405060708090a0b0c;

  logic [7:0] exp_key [16] = '{8'hff, 8'hee, 8'hdd, 8'hcc, 8'hbb, 8'haa, 8'h99, 8'h88,
                               8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
  logic [7:0] exp_blk [16] = '{8'h29, 8'h3a, 8'h36, 8'h39, 8'h6b, 8'h73, 8'h61, 8'h6d,
                               8'h61, 8'h6a, 8'h79, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;

  pyjamask96_loader dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .block_in(block_in), .key_in(key_in), .load(load), .start(start),
    .byte_in(byte_in), .byte_key_in(byte_key_in), .core_valid(core_valid),
    .busy(busy), .done(done)
  );

  pyjamask96_loader #(.GAP_CYCLES(3), .START_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .block_in(block_in), .key_in(key_in), .load(load_b), .start(start_b),
    .byte_in(byte_in_b), .byte_key_in(byte_key_in_b), .core_valid(core_valid),
    .busy(busy_b), .done(done_b)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({in_ready, load, start, busy, done, byte_in, byte_key_in} !== 21'd0) begin
      errors++;
      $display("[TB] FAIL reset_a: got %h expected 0", {in_ready, load, start, busy, done, byte_in, byte_key_in});
    end
    checks++;
    if ({in_ready_b, load_b, start_b, busy_b, done_b, byte_in_b, byte_key_in_b} !== 21'd0) begin
      errors++;
      $display("[TB] FAIL reset_b: got %h expected 0", {in_ready_b, load_b, start_b, busy_b, done_b, byte_in_b, byte_key_in_b});
    end
    reset = 1'b0;
    step();
    checks++;
    if ({in_ready, busy, load, done} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL post_reset ready/busy/load/done: got %b expected 1000", {in_ready, busy, load, done});
    end
  endtask

  task automatic test_load_sequence();
    logic [19:0] exp;
    key_in   = KEY_A;
    block_in = BLK_A;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    block_in = '1;
    key_in   = '1;
    for (int i = 0; i < 16; i++) begin
      exp = {4'b1010, exp_blk[i], exp_key[i]};
      checks++;
      if ({load, start, busy, in_ready, byte_in, byte_key_in} !== exp) begin
        errors++;
        $display("[TB] FAIL load_byte%0d: got %h expected %h", i, {load, start, busy, in_ready, byte_in, byte_key_in}, exp);
      end
      step();
    end
  endtask

  task automatic test_gap_start();
    checks++;
    if ({load, start, busy, in_ready, byte_in, byte_key_in} !== 20'h20000) begin
      errors++;
      $display("[TB] FAIL gap_cycle: got %h expected 20000", {load, start, busy, in_ready, byte_in, byte_key_in});
    end
    step();
    for (int j = 0; j < 2; j++) begin
      checks++;
      if ({load, start, busy, in_ready, byte_in, byte_key_in} !== 20'h60000) begin
        errors++;
        $display("[TB] FAIL start_cycle%0d: got %h expected 60000", j, {load, start, busy, in_ready, byte_in, byte_key_in});
      end
      step();
    end
    checks++;
    if ({load, start, busy, in_ready, done} !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL wait_v_entry: got %b expected 00100", {load, start, busy, in_ready, done});
    end
  endtask

  task automatic test_done();
    core_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if ({done, busy} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL valid_window%0d done/busy: got %b expected 01", k, {done, busy});
      end
      step();
    end
    core_valid = 1'b0;
    checks++;
    if ({done, busy} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL valid_fall done/busy: got %b expected 01", {done, busy});
    end
    step();
    checks++;
    if ({done, in_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL done_pulse done/ready: got %b expected 10", {done, in_ready});
    end
    step();
    checks++;
    if ({done, in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL after_done done/ready: got %b expected 01", {done, in_ready});
    end
  endtask

  task automatic test_ignore_during_load();
    logic [19:0] exp;
    key_in   = KEY_A;
    block_in = BLK_A;
    in_valid = 1'b1;
    step();
    block_in = BLK_B;
    key_in   = KEY_B;
    for (int i = 0; i < 16; i++) begin
      exp = {4'b1010, exp_blk[i], exp_key[i]};
      checks++;
      if ({load, start, busy, in_ready, byte_in, byte_key_in} !== exp) begin
        errors++;
        $display("[TB] FAIL ignore_byte%0d: got %h expected %h", i, {load, start, busy, in_ready, byte_in, byte_key_in}, exp);
      end
      step();
    end
    step();
    step();
    step();
    core_valid = 1'b1;
    step();
    core_valid = 1'b0;
    step();
    checks++;
    if ({done, in_ready, load} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL ignore_done done/ready/load: got %b expected 100", {done, in_ready, load});
    end
    step();
    checks++;
    if ({done, in_ready, load} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL ignore_ready done/ready/load: got %b expected 010", {done, in_ready, load});
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({load, start, busy, in_ready, byte_in, byte_key_in} !== {4'b1010, 8'h0c, 8'h00}) begin
      errors++;
      $display("[TB] FAIL second_accept: got %h expected a0c00", {load, start, busy, in_ready, byte_in, byte_key_in});
    end
  endtask

  task automatic test_reset_mid();
    for (int s = 0; s < 7; s++) step();
    checks++;
    if ({load, start, busy, in_ready, byte_in, byte_key_in} !== {4'b1010, 8'h05, 8'h07}) begin
      errors++;
      $display("[TB] FAIL byte7_before_reset: got %h expected a0507", {load, start, busy, in_ready, byte_in, byte_key_in});
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({in_ready, load, start, busy, done, byte_in, byte_key_in} !== 21'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got %h expected 0", {in_ready, load, start, busy, done, byte_in, byte_key_in});
    end
    step();
    checks++;
    if ({in_ready, busy, done, load} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL mid_reset_idle ready/busy/done/load: got %b expected 1000", {in_ready, busy, done, load});
    end
    key_in   = KEY_A;
    block_in = BLK_A;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if ({load, byte_in, byte_key_in} !== {1'b1, 8'h29, 8'hff}) begin
      errors++;
      $display("[TB] FAIL restart_byte0: got %h expected 129ff", {load, byte_in, byte_key_in});
    end
    step();
    checks++;
    if ({load, byte_in, byte_key_in} !== {1'b1, 8'h3a, 8'hee}) begin
      errors++;
      $display("[TB] FAIL restart_byte1: got %h expected 13aee", {load, byte_in, byte_key_in});
    end
  endtask

  task automatic test_override();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    key_in   = KEY_A;
    block_in = BLK_A;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if ({load_b, start_b, byte_in_b, byte_key_in_b} !== {2'b10, 8'h29, 8'hff}) begin
      errors++;
      $display("[TB] FAIL ovr_byte0: got %h expected 229ff", {load_b, start_b, byte_in_b, byte_key_in_b});
    end
    for (int s = 0; s < 15; s++) step();
    checks++;
    if ({load_b, start_b, byte_in_b, byte_key_in_b} !== {2'b10, 8'h00, 8'h00}) begin
      errors++;
      $display("[TB] FAIL ovr_byte15: got %h expected 20000", {load_b, start_b, byte_in_b, byte_key_in_b});
    end
    step();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({load_b, start_b, busy_b} !== 3'b001) begin
        errors++;
        $display("[TB] FAIL ovr_gap%0d load/start/busy: got %b expected 001", g, {load_b, start_b, busy_b});
      end
      step();
    end
    checks++;
    if ({load_b, start_b, busy_b} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL ovr_start load/start/busy: got %b expected 011", {load_b, start_b, busy_b});
    end
    step();
    checks++;
    if ({load_b, start_b, busy_b} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL ovr_after_start load/start/busy: got %b expected 001", {load_b, start_b, busy_b});
    end
    core_valid = 1'b1;
    step();
    core_valid = 1'b0;
    step();
    checks++;
    if ({done_b, in_ready_b} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL ovr_done done/ready: got %b expected 10", {done_b, in_ready_b});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_sequence();
    test_gap_start();
    test_done();
    test_ignore_during_load();
    test_reset_mid();
    test_override();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
